// File: rtl/hd_man_pkg.sv
// Shared definitions for the HD encoder manipulator path: FSM states,
// default widths and the output beat type.
package hd_man_pkg;

  localparam int VALUE_WIDTH_DEF = 7;
  localparam int CHUNK_WIDTH_DEF = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  typedef logic [CHUNK_WIDTH_DEF-1:0] chunk_t;

endpackage

// File: rtl/unary_encoder.sv
// Thermometer encoder: output bit i is set iff i <= value_i (unsigned).
// The comparison is done one bit wider than the input so the top index
// never wraps.
module unary_encoder
  import hd_man_pkg::*;
#(
  parameter int INPUT_WIDTH = VALUE_WIDTH_DEF
) (
  input  logic [INPUT_WIDTH-1:0]      value_i,
  output logic [(2**INPUT_WIDTH)-1:0] mask_o
);

  localparam int OUT_WIDTH = 2**INPUT_WIDTH;

  // Set every mask bit whose index does not exceed the input value.
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      mask_o[i] = ({1'b0, value_i} >= (INPUT_WIDTH+1)'(i));
    end
  end

endmodule

// File: rtl/unary_level_serializer.sv
// Level hypervector serializer: captures a quantized value and a seed
// hypervector, forms seed ^ thermometer(value) and streams it out as
// NUM_CHUNKS beats. A new transaction may be accepted on the last beat's
// handshake, so consecutive transactions run without an idle cycle.
module unary_level_serializer
  import hd_man_pkg::*;
#(
  parameter int VALUE_WIDTH = VALUE_WIDTH_DEF,
  parameter int CHUNK_WIDTH = CHUNK_WIDTH_DEF,
  localparam int HV_WIDTH   = 2**VALUE_WIDTH,
  localparam int NUM_CHUNKS = HV_WIDTH / CHUNK_WIDTH,
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [VALUE_WIDTH-1:0] value_i,
  input  logic [HV_WIDTH-1:0]    seed_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [CHUNK_WIDTH-1:0] chunk_o,
  output logic [IDX_W-1:0]       chunk_idx_o,
  output logic                   last_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   busy_o
);

  if ((HV_WIDTH % CHUNK_WIDTH) != 0 || NUM_CHUNKS < 2) begin : g_bad_params
    $error("unary_level_serializer: HV_WIDTH must be a multiple of CHUNK_WIDTH with at least 2 chunks");
  end

  state_e                                   state_q, state_d;
  logic [VALUE_WIDTH-1:0]                   value_q, value_d;
  logic [HV_WIDTH-1:0]                      seed_q, seed_d;
  logic [IDX_W-1:0]                         idx_q, idx_d;
  logic [HV_WIDTH-1:0]                      levelMask;
  logic [NUM_CHUNKS-1:0][CHUNK_WIDTH-1:0]   hvChunks;
  logic                                     streaming;
  logic                                     isLast;
  logic                                     acceptEvt;
  logic                                     beatEvt;

  unary_encoder #(
    .INPUT_WIDTH(VALUE_WIDTH)
  ) u_unary_encoder (
    .value_i(value_q),
    .mask_o (levelMask)
  );

  // Output beats come only from registered operands; reset blanks them at once.
  always_comb begin
    hvChunks    = seed_q ^ levelMask;
    streaming   = (state_q == STREAM) && !rst_i;
    isLast      = streaming && (idx_q == IDX_W'(NUM_CHUNKS - 1));
    valid_o     = streaming;
    busy_o      = streaming;
    last_o      = isLast;
    chunk_idx_o = streaming ? idx_q : '0;
    chunk_o     = streaming ? hvChunks[idx_q] : '0;
    ready_o     = !rst_i && ((state_q == IDLE) || (isLast && ready_i));
    acceptEvt   = valid_i && ready_o;
    beatEvt     = streaming && ready_i;
  end

  // Advance the beat index on each handshake; a new accept overrides the wrap to IDLE.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    seed_d  = seed_q;
    idx_d   = idx_q;
    if (beatEvt) begin
      if (isLast) begin
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
    if (acceptEvt) begin
      value_d = value_i;
      seed_d  = seed_i;
      idx_d   = '0;
      state_d = STREAM;
    end
  end

  // State registers with synchronous reset; reset drops any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      value_q <= '0;
      seed_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      seed_q  <= seed_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_unary_level_serializer.sv
// Testbench for unary_level_serializer: directed scenarios followed by
// random traffic, all checked cycle by cycle against a queue-based
// transaction model.
module tb_unary_level_serializer;
  import hd_man_pkg::*;

  localparam int VW = 7;
  localparam int CW = 32;
  localparam int HW = 2**VW;
  localparam int NC = HW / CW;
  localparam int IW = $clog2(NC);

  typedef struct {
    chunk_t data;
    int     idx;
  } beat_t;

  logic          clk;
  logic          rst;
  logic [VW-1:0] value;
  logic [HW-1:0] seed;
  logic          validIn;
  logic          readyOut;
  chunk_t        chunk;
  logic [IW-1:0] chunkIdx;
  logic          last;
  logic          validOut;
  logic          readyIn;
  logic          busy;

  beat_t pendQ[$];
  int    nAsserts = 0;
  int    nFails   = 0;

  unary_level_serializer #(
    .VALUE_WIDTH(VW),
    .CHUNK_WIDTH(CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .value_i    (value),
    .seed_i     (seed),
    .valid_i    (validIn),
    .ready_o    (readyOut),
    .chunk_o    (chunk),
    .chunk_idx_o(chunkIdx),
    .last_o     (last),
    .valid_o    (validOut),
    .ready_i    (readyIn),
    .busy_o     (busy)
  );

  // Free-running clock; inputs change on the falling edge, the DUT samples on the rising edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Level hypervector: seed XOR a run of (value+1) ones from bit 0.
  function automatic logic [HW-1:0] levelHv(input logic [VW-1:0] v, input logic [HW-1:0] s);
    int          onesCount;
    logic [HW:0] ones;
    onesCount = int'(v) + 1;
    ones      = ({{HW{1'b0}}, 1'b1} << onesCount) - 1;
    return s ^ ones[HW-1:0];
  endfunction

  // Compare every DUT output against what the pending-beat queue predicts.
  task automatic checkOutput();
    logic   expValid;
    logic   expReady;
    logic   expLast;
    chunk_t expChunk;
    int     expIdx;
    expValid = !rst && (pendQ.size() > 0);
    expLast  = expValid && (pendQ[0].idx == NC - 1);
    expChunk = expValid ? pendQ[0].data : '0;
    expIdx   = expValid ? pendQ[0].idx : 0;
    expReady = !rst && (!expValid || (expLast && readyIn));
    check("valid_o", 32'(validOut), 32'(expValid));
    check("busy_o", 32'(busy), 32'(expValid));
    check("ready_o", 32'(readyOut), 32'(expReady));
    check("last_o", 32'(last), 32'(expLast));
    check("chunk_idx_o", 32'(chunkIdx), 32'(expIdx));
    check("chunk_o", chunk, expChunk);
  endtask

  // Drive one cycle of inputs, check outputs, then advance the model past the next rising edge.
  task automatic applyStimulus(input logic r, input logic vIn, input logic [VW-1:0] v,
                               input logic [HW-1:0] s, input logic rdy);
    logic          expValid;
    logic          expReady;
    logic [HW-1:0] hv;
    @(negedge clk);
    rst     = r;
    validIn = vIn;
    value   = v;
    seed    = s;
    readyIn = rdy;
    #1;
    checkOutput();
    expValid = !rst && (pendQ.size() > 0);
    expReady = !rst && (!expValid || (pendQ[0].idx == NC - 1 && readyIn));
    if (rst) begin
      pendQ.delete();
    end else begin
      if (expValid && readyIn) void'(pendQ.pop_front());
      if (validIn && expReady) begin
        hv = levelHv(value, seed);
        for (int k = 0; k < NC; k++) begin
          pendQ.push_back('{data: hv[k*CW +: CW], idx: k});
        end
      end
    end
  endtask

  // Directed scenarios, then random traffic with occasional resets.
  initial begin
    logic [HW-1:0] ones;
    logic [HW-1:0] rs;
    ones    = '1;
    rst     = 1'b1;
    validIn = 1'b0;
    value   = '0;
    seed    = '0;
    readyIn = 1'b0;

    $display("[TB] reset");
    applyStimulus(1, 1, 7'd3, '0, 1);
    applyStimulus(1, 0, 7'd0, '0, 1);
    applyStimulus(0, 0, 7'd0, '0, 1);

    $display("[TB] value 0, seed 0");
    applyStimulus(0, 1, 7'd0, '0, 1);
    repeat (5) applyStimulus(0, 0, 7'd0, '0, 1);

    $display("[TB] value 40, seed 0");
    applyStimulus(0, 1, 7'd40, '0, 1);
    repeat (5) applyStimulus(0, 0, 7'd0, '0, 1);

    $display("[TB] seed all ones, values 127 and 0");
    applyStimulus(0, 1, 7'd127, ones, 1);
    repeat (5) applyStimulus(0, 0, 7'd0, '0, 1);
    applyStimulus(0, 1, 7'd0, ones, 1);
    repeat (5) applyStimulus(0, 0, 7'd0, '0, 1);

    $display("[TB] backpressure at beat 1");
    applyStimulus(0, 1, 7'd40, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 1);
    applyStimulus(0, 0, 7'd0, '0, 1);
    repeat (3) applyStimulus(0, 0, 7'd0, '0, 0);
    repeat (5) applyStimulus(0, 0, 7'd0, '0, 1);

    $display("[TB] back-to-back");
    applyStimulus(0, 1, 7'd90, '0, 1);
    repeat (3) applyStimulus(0, 0, 7'd0, '0, 1);
    applyStimulus(0, 1, 7'd5, '0, 1);
    repeat (5) applyStimulus(0, 0, 7'd0, '0, 1);

    $display("[TB] reset mid-stream");
    applyStimulus(0, 1, 7'd100, ones, 1);
    repeat (2) applyStimulus(0, 0, 7'd0, '0, 1);
    applyStimulus(1, 0, 7'd0, '0, 1);
    repeat (4) applyStimulus(0, 0, 7'd0, '0, 1);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
                    VW'($urandom), rs, ($urandom_range(0, 3) != 0));
    end
    repeat (8) applyStimulus(0, 0, 7'd0, '0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
